keypad_scan: RTL

Scanner for a 4x4 matrix keypad (Pmod KYPD style), the input-side counterpart of the multiplexed seven-segment driver. The block drives one keypad column low at a time and samples the active-low rows. It debounces over whole scan frames and encodes a single pressed key to a hex nibble. Accepted keys shift into a 16-bit entry register whose output feeds the display driver's `display_data` directly.

---
 rtl/keypad_pkg.sv | 19 +
 rtl/sync2.sv | 25 ++
 rtl/keypad_scan.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

  // Per-frame classification of the pressed map.
  typedef enum logic [1:0] {FR_NONE, FR_ONE, FR_MULTI} frame_t;

  localparam logic [3:0] COL_RESET = 4'b1110;

  // Index r*4+c -> hex code printed on the key.
  localparam logic [3:0] KEY_LUT [0:15] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for slow asynchronous inputs (keypad rows, switches, buttons).
module sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: reset to the input's idle level so no phantom activity follows reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, frame-level debounce, hex encode and entry shift register.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int DWELL_BITS      = 16,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        clear_n,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  input  logic        entry_clr,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] entry
);

  localparam logic [3:0] DF = 4'(DEBOUNCE_FRAMES);

  logic [3:0]            row_sync;
  logic [DWELL_BITS-1:0] dwell_cnt;
  logic [1:0]            col_idx;
  logic [15:0]           map_q, map_d;
  logic                  dwell_end, frame_end;
  logic [4:0]            hits;
  logic [3:0]            hit_idx, frame_code;
  frame_t                frame;

  state_t     state_q, state_d;
  logic [3:0] cand_q, cand_d, cnt_q, cnt_d;
  logic       accept;
  logic [3:0] accept_code;

  sync2 #(.WIDTH(4), .RESET_VAL(4'hF)) u_row_sync (
    .clk   (clk),
    .rst_n (clear_n),
    .d     (row_n),
    .q     (row_sync)
  );

  assign dwell_end = &dwell_cnt;
  assign frame_end = dwell_end && (col_idx == 2'd3);

  // Merge the current column's sample into the accumulated map.
  always_comb begin
    map_d = map_q;
    for (int r = 0; r < 4; r++) map_d[{2'(r), col_idx}] = ~row_sync[r];
  end

  always_comb begin
    hits    = '0;
    hit_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (map_d[i]) begin
        hits    = hits + 5'd1;
        hit_idx = 4'(i);
      end
    end
  end

  assign frame      = (hits == 5'd0) ? FR_NONE : (hits == 5'd1) ? FR_ONE : FR_MULTI;
  assign frame_code = KEY_LUT[hit_idx];

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      dwell_cnt <= '0;
      col_idx   <= '0;
      col_n     <= COL_RESET;
      map_q     <= '0;
    end else begin
      dwell_cnt <= dwell_cnt + DWELL_BITS'(1);
      if (dwell_end) begin
        col_n   <= {col_n[2:0], col_n[3]};
        col_idx <= col_idx + 2'd1;
        map_q   <= frame_end ? '0 : map_d;
      end
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    accept_code = cand_q;
    if (frame_end) begin
      unique case (state_q)
        IDLE: if (frame == FR_ONE) begin
          cand_d = frame_code;
          cnt_d  = 4'd1;
          if (DF == 4'd1) begin
            state_d     = HELD;
            accept      = 1'b1;
            accept_code = frame_code;
          end else begin
            state_d = DEBOUNCE;
          end
        end
        DEBOUNCE: if (frame == FR_ONE) begin
          if (frame_code == cand_q) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == DF) begin
              state_d = HELD;
              accept  = 1'b1;
            end
          end else begin
            cand_d = frame_code;
            cnt_d  = 4'd1;
          end
        end else begin
          state_d = IDLE;
        end
        HELD: if (frame == FR_NONE) begin
          cnt_d   = 4'd1;
          state_d = (DF == 4'd1) ? IDLE : RELEASE;
        end
        RELEASE: if (frame == FR_NONE) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == DF) state_d = IDLE;
        end else begin
          state_d = HELD;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q   <= IDLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      entry     <= '0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      key_valid <= accept;
      if (accept) begin
        key_code <= accept_code;
        // Clear wins over the old contents, then the new code shifts in.
        entry    <= {(entry_clr ? 12'h000 : entry[11:0]), accept_code};
      end else if (entry_clr) begin
        entry    <= '0;
      end
    end
  end

  assign key_held = (state_q == HELD) || (state_q == RELEASE);

endmodule
